// File: rtl/shared_mem_copy_engine_pkg.sv
// shared_mem_copy_engine_pkg: shared types and defaults for the copy/fill engine
//   DEF_ADDR_W / DEF_DATA_W : default memory address / word widths (16x8 memory)
//   state_t                 : FSM encoding S_IDLE, S_RD, S_WR, S_DONE (2 bits)
//   CMD_COPY / CMD_FILL     : values of cmd_fill
package shared_mem_copy_engine_pkg;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;
    localparam logic CMD_COPY = 1'b0;
    localparam logic CMD_FILL = 1'b1;
endpackage

// File: rtl/shared_mem_copy_engine_if.sv
// shared_mem_copy_engine_if: command handshake plus memory-port bundle of the engine
//   cmd_*     : command offer (valid/ready, fill flag, src, dst, len, pattern)
//   busy/done : job status
//   mem_*     : one port of the shared memory (addr, wdata, we, re, registered rdata)
//   master    : engine side; slave : command source and memory side
interface shared_mem_copy_engine_if import shared_mem_copy_engine_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_fill;
    logic [ADDR_W-1:0] cmd_src;
    logic [ADDR_W-1:0] cmd_dst;
    logic [ADDR_W:0]   cmd_len;
    logic [DATA_W-1:0] cmd_pattern;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  cmd_valid, cmd_fill, cmd_src, cmd_dst, cmd_len, cmd_pattern, mem_rdata,
        output cmd_ready, busy, done, mem_addr, mem_wdata, mem_we, mem_re
    );

    modport slave (
        output cmd_valid, cmd_fill, cmd_src, cmd_dst, cmd_len, cmd_pattern, mem_rdata,
        input  cmd_ready, busy, done, mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/shared_mem_copy_engine.sv
// shared_mem_copy_engine: drives one shared-memory port to copy or fill a block of words
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : master view of shared_mem_copy_engine_if (command handshake, status,
//              memory address/wdata/we/re out, registered memory read data in)
module shared_mem_copy_engine import shared_mem_copy_engine_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input logic                     clk,
    input logic                     rst,
    shared_mem_copy_engine_if.master bus
);
    state_t            state;
    logic              fill_r;
    logic [ADDR_W-1:0] src_r;
    logic [ADDR_W-1:0] dst_r;
    logic [ADDR_W:0]   len_r;
    logic [ADDR_W:0]   i_r;
    logic [ADDR_W:0]   i_nx;
    logic [DATA_W-1:0] pat_r;

    assign i_nx = i_r + 1'b1;

    // The only combinational path from mem_rdata: in WR of a copy the word read
    // in the preceding RD is forwarded straight into the write.
    assign bus.mem_wdata = (state == S_WR) ? ((fill_r == CMD_FILL) ? pat_r : bus.mem_rdata) : '0;

    // Address adds are ADDR_W bits wide so src+i and dst+i wrap around the memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            bus.cmd_ready <= 1'b1;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_re    <= 1'b0;
            i_r           <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.cmd_valid) begin
                    fill_r        <= bus.cmd_fill;
                    src_r         <= bus.cmd_src;
                    dst_r         <= bus.cmd_dst;
                    len_r         <= bus.cmd_len;
                    pat_r         <= bus.cmd_pattern;
                    i_r           <= '0;
                    bus.cmd_ready <= 1'b0;
                    if (bus.cmd_len == '0) begin
                        state    <= S_DONE;
                        bus.done <= 1'b1;
                    end else if (bus.cmd_fill == CMD_COPY) begin
                        state        <= S_RD;
                        bus.busy     <= 1'b1;
                        bus.mem_re   <= 1'b1;
                        bus.mem_addr <= bus.cmd_src;
                    end else begin
                        state        <= S_WR;
                        bus.busy     <= 1'b1;
                        bus.mem_we   <= 1'b1;
                        bus.mem_addr <= bus.cmd_dst;
                    end
                end
                S_RD: begin
                    state        <= S_WR;
                    bus.mem_re   <= 1'b0;
                    bus.mem_we   <= 1'b1;
                    bus.mem_addr <= dst_r + i_r[ADDR_W-1:0];
                end
                S_WR: begin
                    i_r <= i_nx;
                    if (i_nx == len_r) begin
                        state        <= S_DONE;
                        bus.busy     <= 1'b0;
                        bus.done     <= 1'b1;
                        bus.mem_we   <= 1'b0;
                        bus.mem_addr <= '0;
                    end else if (fill_r == CMD_FILL) begin
                        bus.mem_addr <= dst_r + i_nx[ADDR_W-1:0];
                    end else begin
                        state        <= S_RD;
                        bus.mem_we   <= 1'b0;
                        bus.mem_re   <= 1'b1;
                        bus.mem_addr <= src_r + i_nx[ADDR_W-1:0];
                    end
                end
                S_DONE: begin
                    state         <= S_IDLE;
                    bus.done      <= 1'b0;
                    bus.cmd_ready <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shared_mem_copy_engine.sv
// tb_shared_mem_copy_engine: drives the engine against a port-A/port-B memory model and
// checks cycle timing and final memory contents against a sequential reference model
module tb_shared_mem_copy_engine;
    import shared_mem_copy_engine_pkg::*;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shared_mem_copy_engine_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    shared_mem_copy_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    int checks = 0;
    int errors = 0;

    // Shared memory: port A is the engine, port B the client; port B is applied last.
    always @(posedge clk) begin
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        if (b_we) mem[b_addr] <= b_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        b_we = 1'b1; b_addr = a; b_wdata = d;
        ref_mem[a] = d;
        @(negedge clk);
        b_we = 1'b0;
    endtask

    // Reference: words processed one at a time in ascending order, addresses modulo depth.
    function automatic void ref_job(input logic fill, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                                    input logic [AW:0] len, input logic [DW-1:0] pat);
        for (int i = 0; i < int'(len); i++)
            ref_mem[(int'(dst) + i) % DEPTH] = fill ? pat : ref_mem[(int'(src) + i) % DEPTH];
    endfunction

    task automatic check_mem(input string tag);
        for (int k = 0; k < DEPTH; k++)
            check($sformatf("%s mem[%0d]", tag, k), 32'(mem[k]), 32'(ref_mem[k]));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " ready"}, 32'(bus.cmd_ready), 1);
        check({tag, " busy"},  32'(bus.busy), 0);
        check({tag, " done"},  32'(bus.done), 0);
        check({tag, " mem"},   {bus.mem_we, bus.mem_re, 18'(bus.mem_addr), 12'(bus.mem_wdata)}, 0);
    endtask

    task automatic run_job(input string tag, input logic fill, input logic [AW-1:0] src,
                           input logic [AW-1:0] dst, input logic [AW:0] len, input logic [DW-1:0] pat);
        int cyc, lat, bad, k;
        logic seen, ew, er, eb;
        logic [AW-1:0] ea;
        @(negedge clk);
        check({tag, " ready"}, 32'(bus.cmd_ready), 1);
        bus.cmd_fill = fill; bus.cmd_src = src; bus.cmd_dst = dst;
        bus.cmd_len = len; bus.cmd_pattern = pat; bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_fill = 1'($urandom); bus.cmd_src = AW'($urandom); bus.cmd_dst = AW'($urandom);
        bus.cmd_len = (AW+1)'($urandom); bus.cmd_pattern = DW'($urandom);
        lat = (len == 0) ? 1 : fill ? int'(len) + 1 : 2 * int'(len) + 1;
        cyc = 1; bad = 0; seen = 1'b0;
        while (!seen && cyc <= lat + 5) begin
            ew = 1'b0; er = 1'b0; ea = '0;
            if (len != 0 && cyc < lat) begin
                if (fill) begin
                    ew = 1'b1; ea = AW'(int'(dst) + cyc - 1);
                end else if (cyc % 2 == 1) begin
                    k = (cyc - 1) / 2; er = 1'b1; ea = AW'(int'(src) + k);
                end else begin
                    k = cyc / 2 - 1; ew = 1'b1; ea = AW'(int'(dst) + k);
                end
            end
            eb = (len != 0) && (cyc < lat);
            if (bus.mem_we !== ew || bus.mem_re !== er || bus.mem_addr !== ea || bus.busy !== eb ||
                (!ew && bus.mem_wdata !== '0))
                bad++;
            if (bus.done === 1'b1) seen = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        check({tag, " latency"}, 32'(cyc), 32'(lat));
        check({tag, " port sequence"}, 32'(bad), 0);
        ref_job(fill, src, dst, len, pat);
        check_mem(tag);
        @(negedge clk);
        check({tag, " done pulse"}, 32'(bus.done), 0);
    endtask

    initial begin
        int cyc, n_done, first, second;
        b_we = 1'b0; b_addr = '0; b_wdata = '0;
        bus.cmd_valid = 1'b0; bus.cmd_fill = 1'b0; bus.cmd_src = '0; bus.cmd_dst = '0;
        bus.cmd_len = '0; bus.cmd_pattern = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");

        for (int k = 0; k < DEPTH; k++) poke(AW'(k), DW'($urandom));

        run_job("fill4x3", CMD_FILL, 4'd0, 4'd4, 5'd3, 8'hA5);

        poke(4'd0, 8'h11); poke(4'd1, 8'h22); poke(4'd2, 8'h33); poke(4'd3, 8'h44);
        run_job("copy0to8", CMD_COPY, 4'd0, 4'd8, 5'd4, 8'h00);
        check("copy0to8 word11", 32'(mem[11]), 32'h44);

        poke(4'd14, 8'hAA); poke(4'd15, 8'hBB); poke(4'd0, 8'hCC); poke(4'd1, 8'hDD);
        run_job("wrap", CMD_COPY, 4'd14, 4'd1, 5'd4, 8'h00);
        check("wrap word4", 32'(mem[4]), 32'hAA);

        run_job("len0", CMD_COPY, 4'd3, 4'd7, 5'd0, 8'h99);
        run_job("clear16", CMD_FILL, 4'd0, 4'd0, 5'd16, 8'h00);

        for (int k = 0; k < DEPTH; k++) poke(AW'(k), DW'($urandom));
        for (int n = 0; n < 6; n++)
            run_job($sformatf("rand%0d", n), 1'($urandom), AW'($urandom), AW'($urandom),
                    (AW+1)'($urandom_range(0, DEPTH)), DW'($urandom));

        // Command held valid while busy: second command must wait for IDLE.
        @(negedge clk);
        check("bp ready", 32'(bus.cmd_ready), 1);
        bus.cmd_fill = CMD_FILL; bus.cmd_src = 4'd9; bus.cmd_dst = 4'd2;
        bus.cmd_len = 5'd2; bus.cmd_pattern = 8'h5A; bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_fill = CMD_COPY; bus.cmd_src = 4'd2; bus.cmd_dst = 4'd12;
        bus.cmd_len = 5'd2; bus.cmd_pattern = 8'hFF;
        cyc = 1; n_done = 0; first = 0; second = 0;
        while (n_done < 2 && cyc <= 30) begin
            if (bus.done === 1'b1) begin
                n_done++;
                if (n_done == 1) first = cyc; else second = cyc;
            end
            if (n_done < 2) begin
                @(negedge clk);
                cyc++;
            end
        end
        bus.cmd_valid = 1'b0;
        check("bp first done", 32'(first), 3);
        check("bp second done", 32'(second), 9);
        ref_job(CMD_FILL, 4'd9, 4'd2, 5'd2, 8'h5A);
        ref_job(CMD_COPY, 4'd2, 4'd12, 5'd2, 8'hFF);
        check_mem("bp");
        @(negedge clk);

        // Reset in cycle 3 of a len=4 copy: only word 0 reaches memory.
        poke(4'd0, 8'h5C); poke(4'd1, 8'h6D); poke(4'd8, 8'h01); poke(4'd9, 8'h02);
        @(negedge clk);
        bus.cmd_fill = CMD_COPY; bus.cmd_src = 4'd0; bus.cmd_dst = 4'd8;
        bus.cmd_len = 5'd4; bus.cmd_pattern = 8'h00; bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("midrst");
        rst = 1'b0;
        ref_mem[8] = ref_mem[0];
        check_mem("midrst");
        run_job("after rst", CMD_FILL, 4'd0, 4'd14, 5'd2, 8'h3C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
